// File: rtl/fp_alu_pkg.sv
// Shared opcode map, FSM encoding, sticky-flag layout and result record for
// the sequenced single-precision ALU.
package fp_alu_pkg;

  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_DIV = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_F2I = 4'd9;
  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam int STK_EXC = 0;
  localparam int STK_OVF = 1;
  localparam int STK_UNF = 2;
  localparam int STK_ILL = 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    logic        unf;
    logic        ill;
  } alu_res_t;

  function automatic logic [3:0] op_cycles(input logic [3:0] op, input logic [3:0] fp_cyc,
                                           input logic [3:0] div_cyc);
    case (op)
      OP_DIV:                         return div_cyc;
      OP_MUL, OP_SUB, OP_ADD, OP_F2I: return fp_cyc;
      default:                        return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/fp_alu_core.sv
// Combinational opcode decode and FP units (truncating, denormals flushed to zero).
module fp_alu_core
  import fp_alu_pkg::*;
#(
  parameter int FP_CYCLES  = 2,
  parameter int DIV_CYCLES = 4,
  parameter int SHIFT_BY_B = 1
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic [3:0]  req_op,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        illegal,
  output logic [3:0]  cycles
);

  function automatic logic [31:0] fp_pack(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m);
    if (e > 11'sd254) return {s, 8'hFF, 23'd0};
    if (e < 11'sd1)   return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic alu_res_t fp_mul(input logic [31:0] x, input logic [31:0] y);
    alu_res_t r;
    logic [24:0] ph;
    logic signed [10:0] e;
    logic s;
    r  = '0;
    s  = x[31] ^ y[31];
    ph = 25'(({24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]}) >> 23);
    e  = $signed({3'b0, x[30:23]}) + $signed({3'b0, y[30:23]}) - 11'sd127
       + $signed({10'd0, ph[24]});
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      r.res = QNAN;
      r.exc = 1'b1;
    end else if (x[30:23] == 8'd0 || y[30:23] == 8'd0) begin
      r.res = {s, 31'd0};
    end else begin
      r.ovf = (e > 11'sd254);
      r.unf = (e < 11'sd1);
      r.res = fp_pack(s, e, ph[24] ? ph[23:1] : ph[22:0]);
    end
    return r;
  endfunction

  function automatic alu_res_t fp_div(input logic [31:0] x, input logic [31:0] y);
    alu_res_t r;
    logic [24:0] q;
    logic signed [10:0] e;
    logic s;
    r = '0;
    s = x[31] ^ y[31];
    q = 25'({1'b1, x[22:0], 24'd0} / {24'd0, 1'b1, y[22:0]});
    e = $signed({3'b0, x[30:23]}) - $signed({3'b0, y[30:23]}) + 11'sd126
      + $signed({10'd0, q[24]});
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      r.res = QNAN;
      r.exc = 1'b1;
    end else if (y[30:23] == 8'd0) begin
      r.res = {s, 8'hFF, 23'd0};
      r.exc = 1'b1;
    end else if (x[30:23] == 8'd0) begin
      r.res = {s, 31'd0};
    end else begin
      r.res = fp_pack(s, e, q[24] ? q[23:1] : q[22:0]);
    end
    return r;
  endfunction

  function automatic alu_res_t fp_add(input logic [31:0] x_in, input logic [31:0] y_in);
    alu_res_t r;
    logic [31:0] x, y;
    logic [7:0]  d;
    logic [23:0] mx, my, dm;
    logic [24:0] sum;
    logic [22:0] mant;
    logic signed [10:0] e;
    r = '0; x = x_in; y = y_in; sum = '0; dm = '0; mant = '0;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
      r.res = QNAN;
      r.exc = 1'b1;
    end else if (x[30:23] == 8'd0) begin
      r.res = y;
    end else if (y[30:23] == 8'd0) begin
      r.res = x;
    end else begin
      // Larger magnitude first so the aligned difference never goes negative.
      if (y[30:0] > x[30:0]) begin x = y_in; y = x_in; end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0]};
      my = (d > 8'd23) ? 24'd0 : ({1'b1, y[22:0]} >> d);
      e  = $signed({3'b0, x[30:23]});
      if (x[31] == y[31]) begin
        sum = {1'b0, mx} + {1'b0, my};
        if (sum[24]) begin mant = sum[23:1]; e = e + 11'sd1; end
        else         mant = sum[22:0];
        r.res = fp_pack(x[31], e, mant);
      end else if (mx == my) begin
        r.res = 32'd0;
      end else begin
        dm = mx - my;
        for (int i = 0; i < 23; i++)
          if (!dm[23]) begin dm = dm << 1; e = e - 11'sd1; end
        r.res = fp_pack(x[31], e, dm[22:0]);
      end
    end
    return r;
  endfunction

  function automatic alu_res_t fp_f2i(input logic [31:0] x);
    alu_res_t r;
    logic [31:0] mag;
    r = '0;
    if (x[30:23] >= 8'd158) begin
      r.res = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r.exc = 1'b1;
    end else if (x[30:23] >= 8'd127) begin
      if (x[30:23] >= 8'd150) mag = {8'd0, 1'b1, x[22:0]} << (x[30:23] - 8'd150);
      else                    mag = {8'd0, 1'b1, x[22:0]} >> (8'd150 - x[30:23]);
      r.res = x[31] ? -mag : mag;
    end
    return r;
  endfunction

  alu_res_t   r;
  logic [4:0] shamt;

  always_comb begin
    r     = '0;
    shamt = (SHIFT_BY_B != 0) ? b[4:0] : 5'd1;
    case (op)
      OP_MUL: r = fp_mul(a, b);
      OP_DIV: r = fp_div(a, b);
      OP_SUB: r = fp_add(a, {~b[31], b[30:0]});
      OP_ADD: r = fp_add(a, b);
      OP_F2I: r = fp_f2i(a);
      OP_OR:  r.res = a | b;
      OP_AND: r.res = a & b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: r.res = a << shamt;
      OP_SHR: r.res = a >> shamt;
      OP_NOT: r.res = ~a;
      default: r.ill = 1'b1;
    endcase
  end

  assign result    = r.res;
  assign exception = r.exc;
  assign overflow  = r.ovf;
  assign underflow = r.unf;
  assign illegal   = r.ill;
  assign cycles    = op_cycles(req_op, 4'(FP_CYCLES), 4'(DIV_CYCLES));

endmodule

// File: rtl/fp_alu_seq.sv
// Handshaked, multicycle-timed wrapper around the FP ALU core: captures operands,
// waits the per-op settle time, then holds result and flags under back-pressure.
module fp_alu_seq
  import fp_alu_pkg::*;
#(
  parameter int FP_CYCLES  = 2,
  parameter int DIV_CYCLES = 4,
  parameter int SHIFT_BY_B = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic [3:0]  operation,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_output,
  output logic        exception,
  output logic        overflow,
  output logic        underflow,
  output logic        illegal_op,
  output logic [3:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic        busy
);

  state_t      state, state_nxt;
  logic [31:0] a_p0, b_p0;
  logic [3:0]  op_p0, cnt;
  logic [31:0] res_c;
  logic        exc_c, ovf_c, unf_c, ill_c;
  logic [3:0]  cyc_c, new_flags;
  logic        accept, finish;

  fp_alu_core #(
    .FP_CYCLES (FP_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .SHIFT_BY_B(SHIFT_BY_B)
  ) u_core (
    .a        (a_p0),
    .b        (b_p0),
    .op       (op_p0),
    .req_op   (operation),
    .result   (res_c),
    .exception(exc_c),
    .overflow (ovf_c),
    .underflow(unf_c),
    .illegal  (ill_c),
    .cycles   (cyc_c)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          accept    = in_valid;
          state_nxt = in_valid ? EXEC : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    new_flags          = '0;
    new_flags[STK_EXC] = exc_c;
    new_flags[STK_OVF] = ovf_c;
    new_flags[STK_UNF] = unf_c;
    new_flags[STK_ILL] = ill_c;
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // p0: operand capture and settle counter; output stage loads on EXEC completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_p0         <= '0;
      b_p0         <= '0;
      op_p0        <= '0;
      cnt          <= '0;
      alu_output   <= '0;
      exception    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      illegal_op   <= 1'b0;
      sticky_flags <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_p0  <= a_operand;
        b_p0  <= b_operand;
        op_p0 <= operation;
        cnt   <= cyc_c - 4'd1;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        alu_output <= res_c;
        exception  <= exc_c;
        overflow   <= ovf_c;
        underflow  <= unf_c;
        illegal_op <= ill_c;
      end
      // A clear on the completion edge wipes history but keeps the new result's bits.
      if (finish)          sticky_flags <= (sticky_clr ? 4'd0 : sticky_flags) | new_flags;
      else if (sticky_clr) sticky_flags <= '0;
    end
  end

endmodule

// File: tb/tb_fp_alu_seq.sv
// Directed bench for fp_alu_seq with a real-arithmetic reference model and a
// per-cycle output/sticky scoreboard.
module tb_fp_alu_seq;

  localparam int FP_CYC  = 2;
  localparam int DIV_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, sticky_clr, busy;
  logic [31:0] a_operand, b_operand, alu_output;
  logic [3:0]  operation, sticky_flags;
  logic        exception, overflow, underflow, illegal_op;

  always #5 clk = ~clk;

  fp_alu_seq #(.FP_CYCLES(FP_CYC), .DIV_CYCLES(DIV_CYC), .SHIFT_BY_B(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .alu_output(alu_output),
    .exception(exception), .overflow(overflow), .underflow(underflow),
    .illegal_op(illegal_op), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic        ovf;
    logic        unf;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] exp_sticky = 4'd0;
  logic       clr_pend = 1'b0;
  bit         seen = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(x[30:23]) - 127.0));
    return x[31] ? -v : v;
  endfunction

  // Returns {bits, overflow, underflow}; mantissa truncated.
  function automatic logic [33:0] r2f(input real r);
    real  m;
    int   e;
    logic s;
    if (r == 0.0) return 34'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    if (e > 254) return {s, 8'hFF, 23'd0, 2'b10};
    if (e < 1)   return {s, 31'd0, 2'b01};
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0)), 2'b00};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        r;
    real         ra, rb, v;
    logic [33:0] pk;
    r.res = 32'd0; r.exc = 1'b0; r.ovf = 1'b0; r.unf = 1'b0; r.ill = 1'b0;
    r.acc = cyc + 1;
    r.lat = (op == 4'd2) ? DIV_CYC : (op == 4'd1 || op == 4'd3 || op == 4'd9 || op == 4'd10) ? FP_CYC : 1;
    case (op)
      4'd1, 4'd2, 4'd3, 4'd10: begin
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
          r.exc = 1'b1; r.res = 32'h7FC0_0000;
        end else if (op == 4'd2 && b[30:23] == 8'd0) begin
          r.exc = 1'b1; r.res = {a[31] ^ b[31], 8'hFF, 23'd0};
        end else begin
          ra = f2r(a); rb = f2r(b);
          case (op)
            4'd1:    v = ra * rb;
            4'd2:    v = ra / rb;
            4'd3:    v = ra - rb;
            default: v = ra + rb;
          endcase
          pk = r2f(v);
          r.res = pk[33:2];
          if (op == 4'd1) begin r.ovf = pk[1]; r.unf = pk[0]; end
        end
      end
      4'd9: begin
        ra = f2r(a);
        if (a[30:23] == 8'hFF || ra >= 2147483648.0 || ra <= -2147483648.0) begin
          r.exc = 1'b1; r.res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else r.res = 32'($rtoi(ra));
      end
      4'd4:  r.res = a | b;
      4'd5:  r.res = a & b;
      4'd6:  r.res = a ^ b;
      4'd7:  r.res = a << b[4:0];
      4'd8:  r.res = a >> b[4:0];
      4'd11: r.res = ~a;
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_sticky = 4'd0;
      clr_pend   = 1'b0;
      seen       = 1'b0;
    end else begin
      if (clr_pend) exp_sticky = 4'd0;
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid actual=1 required=0");
        end else begin
          cur = q[0];
          if (!seen) begin
            seen = 1'b1;
            exp_sticky = exp_sticky | {cur.ill, cur.unf, cur.ovf, cur.exc};
            chk("sb_latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
          chk("sb_result", alu_output, cur.res);
          chk("sb_flags", {28'd0, illegal_op, underflow, overflow, exception},
              {28'd0, cur.ill, cur.unf, cur.ovf, cur.exc});
          if (out_ready) begin q.delete(0); seen = 1'b0; end
        end
      end
      chk("sb_sticky", {28'd0, sticky_flags}, {28'd0, exp_sticky});
      if (in_valid && in_ready) q.push_back(model(a_operand, b_operand, operation));
      clr_pend = sticky_clr;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic rdy);
    int n;
    @(posedge clk); #1;
    a_operand = a; b_operand = b; operation = op; in_valid = 1'b1; out_ready = rdy;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_operand = 32'hDEAD_BEEF; b_operand = 32'h1234_5678; operation = 4'd15;
  endtask

  task automatic wait_result(output logic [31:0] r, output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk("busy_exec", 32'(busy), 32'd1);
      chk("in_ready_exec", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL result_timeout actual=no_out_valid required=out_valid");
    end
    r = alu_output;
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] want, input int want_lat);
    logic [31:0] r;
    int          lat;
    issue(a, b, op, 1'b1);
    wait_result(r, lat);
    chk({name, "_result"}, r, want);
    chk({name, "_latency"}, 32'(lat), 32'(want_lat));
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
    a_operand = '0; b_operand = '0; operation = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_output", alu_output, 32'd0);
    chk("rst_flags", {28'd0, illegal_op, underflow, overflow, exception}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run("add", 32'h3F80_0000, 32'h4000_0000, 4'd10, 32'h4040_0000, FP_CYC);
    chk("add_flags", {28'd0, illegal_op, underflow, overflow, exception}, 32'd0);
    run("div", 32'h40C0_0000, 32'h4000_0000, 4'd2, 32'h4040_0000, DIV_CYC);

    // Back-pressure, then a back-to-back AND accepted in DONE.
    issue(32'h4000_0000, 32'h4040_0000, 4'd1, 1'b0);
    wait_result(r, lat);
    chk("mul_result", r, 32'h40C0_0000);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold", alu_output, 32'h40C0_0000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    issue(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 1'b1);
    wait_result(r, lat);
    chk("b2b_and_result", r, 32'hF000_F000);
    chk("b2b_and_latency", 32'(lat), 32'd1);

    run("shl", 32'h0000_0001, 32'd4, 4'd7, 32'h0000_0010, 1);
    run("shr", 32'h8000_0000, 32'd31, 4'd8, 32'h0000_0001, 1);
    run("shl0", 32'hA5A5_0001, 32'd0, 4'd7, 32'hA5A5_0001, 1);
    run("not", 32'h0000_FFFF, 32'd0, 4'd11, 32'hFFFF_0000, 1);
    run("xor", 32'h1234_5678, 32'hFFFF_0000, 4'd6, 32'hEDCB_5678, 1);
    run("sub_norm", 32'h3F80_0000, 32'h3F00_0000, 4'd3, 32'h3F00_0000, FP_CYC);
    run("f2i_neg", 32'hC0E0_0000, 32'd0, 4'd9, 32'hFFFF_FFF9, FP_CYC);

    run("illegal", 32'h1111_1111, 32'h2222_2222, 4'd13, 32'd0, 1);
    chk("illegal_flag", 32'(illegal_op), 32'd1);
    chk("illegal_sticky", {28'd0, sticky_flags}, 32'h8);

    // Clear lands on the same edge as an overflowing multiply completes.
    issue(32'h7F00_0000, 32'h7F00_0000, 4'd1, 1'b1);
    @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    @(negedge clk);
    chk("ovf_out_valid", 32'(out_valid), 32'd1);
    chk("ovf_result", alu_output, 32'h7F80_0000);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_sticky", {28'd0, sticky_flags}, {28'd0, 3'b001, exception});

    // Reset during the division settle window.
    issue(32'h40C0_0000, 32'h4000_0000, 4'd2, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_alu_output", alu_output, 32'd0);
    chk("abort_flags", {28'd0, illegal_op, underflow, overflow, exception}, 32'd0);
    chk("abort_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_pulse", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
    end
    run("sub_after_rst", 32'h4040_0000, 32'h3F80_0000, 4'd3, 32'h4000_0000, FP_CYC);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
